// File: rtl/load_store_unit32_pkg.sv
// rtl/load_store_unit32_pkg.sv - shared constants and state encoding for the load/store unit
package load_store_unit32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align32.sv
// rtl/lsu_align32.sv - byte/half lane extraction, store merge and access legality checks
module lsu_align32
  import load_store_unit32_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_mem_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    w_byte   = i_mem_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half   = i_mem_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    w_signed = ~i_funct3[2];

    case (i_funct3[1:0])
      2'b00:   o_load = {{24{w_signed & w_byte[7]}}, w_byte};
      2'b01:   o_load = {{16{w_signed & w_half[15]}}, w_half};
      default: o_load = i_mem_rdata;
    endcase

    // Sub-word stores keep the untouched lanes of the current memory word.
    o_merged = i_mem_rdata;
    case (i_funct3[1:0])
      2'b00:   o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      2'b01:   o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase

    o_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

    if (i_we)
      o_illegal = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
    else
      o_illegal = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                    (i_funct3 == F3_BU) || (i_funct3 == F3_HU));
  end

endmodule

// File: rtl/load_store_unit32.sv
// rtl/load_store_unit32.sv - RV32I load/store unit over a word-wide, word-write-only memory
module load_store_unit32
  import load_store_unit32_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  lsu_state_e   r_state;
  logic         r_we;
  logic [2:0]   r_funct3;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_wdata;
  logic [N-1:0] r_merged;
  logic [N-1:0] r_rdata;
  logic         r_fault;
  logic         r_resp_valid;

  logic         w_idle;
  logic         w_sel_we;
  logic [2:0]   w_sel_funct3;
  logic [1:0]   w_sel_addr_lo;
  logic [N-1:0] w_load;
  logic [N-1:0] w_merged;
  logic         w_misaligned;
  logic         w_illegal;
  logic         w_fault;
  logic         w_sw_access;

  // Legality is judged on the live request in IDLE, extraction on the latched one afterwards.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_sel_we      = w_idle ? req_we : r_we;
  assign w_sel_funct3  = w_idle ? req_funct3 : r_funct3;
  assign w_sel_addr_lo = w_idle ? req_addr[1:0] : r_addr[1:0];
  assign w_fault       = w_misaligned | w_illegal;

  lsu_align32 u_align (
    .i_we         (w_sel_we),
    .i_funct3     (w_sel_funct3),
    .i_addr_lo    (w_sel_addr_lo),
    .i_mem_rdata  (mem_rdata),
    .i_wdata      (r_wdata),
    .o_load       (w_load),
    .o_merged     (w_merged),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign w_sw_access = (r_state == ST_ACCESS) && r_we && (r_funct3 == F3_W);

  always_comb begin
    mem_we    = w_sw_access || (r_state == ST_WRITE);
    mem_addr  = {2'b00, r_addr[N-1:2]};
    mem_wdata = '0;
    if (w_sw_access)
      mem_wdata = r_wdata;
    else if (r_state == ST_WRITE)
      mem_wdata = r_merged;
  end

  assign req_ready  = w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_merged     <= '0;
      r_rdata      <= '0;
      r_fault      <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_fault  <= w_fault;
            if (w_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            r_rdata      <= w_load;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end else if (r_funct3 == F3_W) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_merged <= w_merged;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit32.md
Name: load_store_unit32

Overview:
Sits between the execute stage and the word-wide data memory. Accepts one load/store request at a time and converts RV32I byte/halfword/word accesses into word-indexed memory accesses. Performs sign/zero extension on loads and read-modify-write for sub-word stores, because the memory has only a whole-word write enable. Returns a single-cycle response pulse with data or a fault flag.

Parameters:
n, 32, datapath and address width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  LSU can accept a request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
req_addr  input  n  byte address
req_wdata  input  n  store data; low byte/half used for SB/SH
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  n  load result; 0 for stores and faults
resp_fault  output  1  misaligned access or illegal funct3, valid with resp_valid
mem_we  output  1  memory write enable
mem_addr  output  n  word index, {2'b00, addr[31:2]}
mem_wdata  output  n  memory write data
mem_rdata  input  n  combinational memory read data for mem_addr

Behaviour:
- Reset (rst_n low, async):
  - State forced to IDLE.
  - resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Requests are ignored while rst_n is low.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - Aligned and legal request -> ACCESS. Otherwise -> RESP with fault set.
- Fault conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 in {011,110,111}.
  - Store funct3 other than 000/001/010.
- ACCESS (one cycle):
  - mem_addr = latched addr >> 2.
  - LW: resp_rdata<=mem_rdata.
  - LB/LBU: extract byte lane addr[1:0] (little-endian, lane k = bits 8k+7:8k); sign- or zero-extend.
  - LH/LHU: extract half lane addr[1]; sign- or zero-extend.
  - SW: mem_we=1, mem_wdata=wdata.
  - Loads and SW -> RESP.
  - SB/SH: mem_we=0; register merged word (mem_rdata with the target lane replaced by wdata[7:0]/[15:0]) -> WRITE.
- WRITE (one cycle): mem_we=1, mem_addr held, mem_wdata = merged word -> RESP.
- RESP (one cycle): resp_valid=1, req_ready=0 -> IDLE.
- Output timing:
  - mem_we, mem_addr and mem_wdata are combinational from state and latched regs.
  - mem_we is 0 outside ACCESS(SW) and WRITE.
- Latency, acceptance edge T:
  - Loads and SW: resp_valid during cycle T+2.
  - SB/SH: resp_valid during T+3.
  - Fault: resp_valid during T+1; no memory write occurs.
- Throughput: no new acceptance until IDLE. req_valid held high is taken on the cycle after RESP.
- No range check: addresses alias modulo memory size; the memory decodes the low index bits.
- Reset mid-operation:
  - Aborts immediately and mem_we drops asynchronously.
  - An SB/SH reset before the WRITE edge leaves memory unchanged.
  - No response is produced for the aborted request.

Decomposition:
- Shared package holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state encoding (IDLE=0, ACCESS=1, WRITE=2, RESP=3).
- One natural combinational sub-module, lsu_align32, takes funct3, addr[1:0], mem_rdata and wdata. It produces:
  - The extended load value.
  - The merged store word.
  - The misaligned and illegal flags.

Test Plan:
- Alignment faults:
  - LW addr 0x12 -> resp_valid at T+1, resp_fault=1, resp_rdata=0, mem_we never high.
  - LH addr 0x11 -> same.
- SW and loads:
  - SW addr 0x10 wdata 0xDEADBEEF -> mem_we at T+1 with mem_addr=4; resp at T+2, fault=0.
  - Then LW 0x10 -> 0xDEADBEEF.
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- Sub-word stores:
  - SB 0x11 wdata 0x123456AA -> single mem_we at T+2, resp at T+3; word 4 = 0xDEADAAEF.
  - Then SH 0x12 wdata 0x00001234 -> word 4 = 0x1234AAEF.
- Back-to-back: req_valid held high with two LWs -> second accepted exactly one cycle after the first RESP; req_ready=0 during ACCESS/RESP.
- Reset mid-operation: assert rst_n low during WRITE of SB 0x10 -> mem_we falls immediately, word unchanged, no resp_valid, req_ready=1 once rst_n released.
- Illegal funct3: load funct3=011 at addr 0x0 -> resp_fault=1 at T+1, resp_rdata=0.
